data_mem_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/data_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults and FSM encoding for the data memory arbiter.
// Imported by the arbiter and by anything that inspects its state.
package mem_arb_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int DATA_W_DEF    = 32;
    localparam int DEPTH_DEF     = 256;
    localparam int MAX_BURST_DEF = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory,
// with bounded lock bursts and a registered read/error response.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;

    logic              gnt0, gnt1, acc;
    logic              sel_we, sel_lock, sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;

    // rr_q names the port that wins the next two-way contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ARB: begin
                    if (req0_valid && req1_valid) begin
                        gnt0 = !rr_q;
                        gnt1 = rr_q;
                    end else begin
                        gnt0 = req0_valid;
                        gnt1 = req1_valid;
                    end
                end
                LOCK0:   gnt0 = req0_valid;
                LOCK1:   gnt1 = req1_valid;
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign acc        = gnt0 | gnt1;

    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (1'b1)
            gnt0: begin
                sel_we    = req0_we;
                sel_lock  = req0_lock;
                sel_addr  = req0_addr;
                sel_wdata = req0_wdata;
            end
            gnt1: begin
                sel_we    = req1_we;
                sel_lock  = req1_lock;
                sel_addr  = req1_addr;
                sel_wdata = req1_wdata;
            end
            default: ;
        endcase
    end

    assign sel_oor   = sel_addr >= ADDR_W'(DEPTH);
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;
    assign mem_we    = acc && sel_we && !sel_oor;

    assign rsp_fire = acc && (!sel_we || sel_oor);
    assign rsp_data = sel_oor ? '0 : mem_rdata;

    // The first locked beat is taken in ARB, so the count starts at 1.
    assign cnt_nxt = (state_q == ARB) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (acc) begin
            rr_d = gnt0;
            if (!sel_lock || cnt_nxt >= CNT_W'(MAX_BURST)) begin
                state_d = ARB;
                cnt_d   = '0;
            end else begin
                state_d = gnt0 ? LOCK0 : LOCK1;
                cnt_d   = cnt_nxt;
            end
        end else if (state_q != ARB) begin
            state_d = ARB;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            rsp0_valid <= gnt0 && rsp_fire;
            rsp0_err   <= gnt0 && sel_oor;
            rsp1_valid <= gnt1 && rsp_fire;
            rsp1_err   <= gnt1 && sel_oor;
            if (gnt0 && rsp_fire) rsp0_rdata <= rsp_data;
            if (gnt1 && rsp_fire) rsp1_rdata <= rsp_data;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, then random traffic
// checked against a transaction-level model of ownership and memory.
module tb_data_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 15;
    localparam int DW   = 32;
    localparam int DEP  = 256;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_we, req0_lock, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid, rsp0_err;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_we, req1_lock, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we),
        .req0_lock(req0_lock), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_we(req1_we),
        .req1_lock(req1_lock), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rsp1_err(rsp1_err),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port memory with combinational read.
    logic [DW-1:0] mem [DEP];
    assign mem_rdata = (mem_addr < AW'(DEP)) ? mem[mem_addr[7:0]] : '0;
    always @(posedge clk)
        if (mem_we && mem_addr < AW'(DEP)) mem[mem_addr[7:0]] <= mem_wdata;

    typedef struct {
        bit          rst;
        bit          v0, we0, l0;
        int          a0;
        logic [31:0] d0;
        bit          v1, we1, l1;
        int          a1;
        logic [31:0] d1;
        bit          er0, er1;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference: who owns the memory, burst length, who wins a tie.
    int          owner, beats, pref;
    bit          pv [2];
    bit          pe [2];
    logic [31:0] pd [2];
    logic [31:0] ref_mem [DEP];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rst, bit v0, bit we0, bit l0, int a0,
                                logic [31:0] d0, bit v1, bit we1, bit l1,
                                int a1, logic [31:0] d1, bit er0, bit er1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.we0 = we0; v.l0 = l0; v.a0 = a0;
        v.d0 = d0; v.v1 = v1; v.we1 = we1; v.l1 = l1; v.a1 = a1;
        v.d1 = d1; v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    task automatic step(input vec_t v, input bit tbl);
        int g;
        bit gw, gl, oor;
        int ga;
        logic [31:0] gd;
        @(negedge clk);
        reset      = v.rst;
        req0_valid = v.v0; req0_we = v.we0; req0_lock = v.l0;
        req0_addr  = AW'(v.a0); req0_wdata = v.d0;
        req1_valid = v.v1; req1_we = v.we1; req1_lock = v.l1;
        req1_addr  = AW'(v.a1); req1_wdata = v.d1;
        #1;
        g = -1;
        if (!v.rst) begin
            if (owner >= 0) begin
                if ((owner == 0) ? v.v0 : v.v1) g = owner;
            end else if (v.v0 && v.v1) g = pref;
            else if (v.v0) g = 0;
            else if (v.v1) g = 1;
        end
        gw = (g == 0) ? v.we0 : v.we1;
        gl = (g == 0) ? v.l0 : v.l1;
        ga = (g == 0) ? v.a0 : v.a1;
        gd = (g == 0) ? v.d0 : v.d1;
        oor = ga >= DEP;
        if (tbl) begin
            chk("tbl_ready0", 32'(req0_ready), 32'(v.er0));
            chk("tbl_ready1", 32'(req1_ready), 32'(v.er1));
        end
        chk("ready0", 32'(req0_ready), 32'(g == 0));
        chk("ready1", 32'(req1_ready), 32'(g == 1));
        chk("mem_we", 32'(mem_we), 32'(g >= 0 && gw && !oor));
        chk("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(ga) : 32'd0);
        if (g >= 0 && gw && !oor) chk("mem_wdata", mem_wdata, gd);
        @(posedge clk);
        pv[0] = 0; pv[1] = 0; pe[0] = 0; pe[1] = 0;
        if (v.rst) begin
            owner = -1; beats = 0; pref = 0;
        end else if (g >= 0) begin
            pref = 1 - g;
            if (!gw || oor) begin
                pv[g] = 1;
                pe[g] = oor;
                pd[g] = oor ? 32'd0 : ref_mem[ga];
            end
            if (gw && !oor) ref_mem[ga] = gd;
            if (gl) begin
                beats = (owner < 0) ? 1 : beats + 1;
                owner = (beats >= MAXB) ? -1 : g;
            end else owner = -1;
        end else owner = -1;
        #1;
        chk("rsp0_valid", 32'(rsp0_valid), 32'(pv[0]));
        chk("rsp0_err", 32'(rsp0_err), 32'(pe[0]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(pv[1]));
        chk("rsp1_err", 32'(rsp1_err), 32'(pe[1]));
        if (pv[0]) chk("rsp0_rdata", rsp0_rdata, pd[0]);
        if (pv[1]) chk("rsp1_rdata", rsp1_rdata, pd[1]);
        if (v.rst) begin
            chk("rst_rdata0", rsp0_rdata, 32'd0);
            chk("rst_rdata1", rsp1_rdata, 32'd0);
        end
    endtask

    vec_t tbl [$];

    initial begin
        vec_t v;
        for (int i = 0; i < DEP; i++) begin
            mem[i]     = 32'hA000_0000 + 32'(i);
            ref_mem[i] = 32'hA000_0000 + 32'(i);
        end
        owner = -1; beats = 0; pref = 0;
        reset = 1'b1;
        req0_valid = 0; req0_we = 0; req0_lock = 0;
        req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_lock = 0;
        req1_addr = '0; req1_wdata = '0;

        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1,0,0,5,0, 1,0,0,6,0, 0,0));
        tbl.push_back(mk(0, 1,0,0,5,0, 1,0,0,6,0, 1,0));
        tbl.push_back(mk(0, 1,0,0,5,0, 0,0,0,0,0, 1,0));
        tbl.push_back(mk(0, 1,0,0,10,0, 1,1,0,10,32'hDEADBEEF, 0,1));
        tbl.push_back(mk(0, 1,0,0,10,0, 1,0,0,11,0, 1,0));
        tbl.push_back(mk(0, 1,0,0,10,0, 1,0,0,11,0, 0,1));
        tbl.push_back(mk(0, 1,0,0,10,0, 1,0,0,11,0, 1,0));
        tbl.push_back(mk(0, 1,1,0,300,32'h12345678, 0,0,0,0,0, 1,0));
        tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
        tbl.push_back(mk(0, 0,0,0,0,0, 1,0,1,20,0, 0,1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 1,0,0,1,0, 1,1,1,21+i,32'(i), 0,1));
        tbl.push_back(mk(0, 1,0,0,1,0, 1,0,1,22,0, 1,0));
        tbl.push_back(mk(0, 1,0,0,1,0, 1,0,1,22,0, 0,1));
        tbl.push_back(mk(0, 1,0,0,1,0, 1,0,1,23,0, 0,1));
        tbl.push_back(mk(0, 1,0,0,1,0, 1,0,1,24,0, 0,1));
        tbl.push_back(mk(1, 1,0,0,1,0, 1,0,1,25,0, 0,0));
        tbl.push_back(mk(0, 1,0,0,2,0, 1,0,1,25,0, 1,0));
        tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));

        foreach (tbl[i]) step(tbl[i], 1'b1);

        for (int i = 0; i < 600; i++) begin
            v.rst = ($urandom_range(0, 79) == 0);
            v.v0  = ($urandom_range(0, 3) != 0);
            v.we0 = $urandom_range(0, 1) == 1;
            v.l0  = ($urandom_range(0, 3) != 0);
            v.a0  = ($urandom_range(0, 9) == 0) ?
                    int'($urandom_range(256, 400)) :
                    int'($urandom_range(0, 15));
            v.d0  = $urandom;
            v.v1  = ($urandom_range(0, 3) != 0);
            v.we1 = $urandom_range(0, 1) == 1;
            v.l1  = ($urandom_range(0, 3) != 0);
            v.a1  = ($urandom_range(0, 9) == 0) ?
                    int'($urandom_range(256, 400)) :
                    int'($urandom_range(0, 15));
            v.d1  = $urandom;
            v.er0 = 0; v.er1 = 0;
            step(v, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
